// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART buffering blocks.
package uart_pkg;

  typedef enum logic [0:0] {
    XON  = 1'b0,
    XOFF = 1'b1
  } flow_state_t;

  localparam int UART_DATA_W_DEFAULT     = 8;
  localparam int UART_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with explicit occupancy counter and flush.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W_DEFAULT,
  parameter int DEPTH  = UART_FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == DEPTH_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered RX->TX UART bridge with full policy, sticky overrun and RTS-style flow control.
// Optional statistics counters are enabled by defining UART_FIFO_BRIDGE_STATS_EN.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W_DEFAULT,
  parameter int DEPTH        = UART_FIFO_DEPTH_DEFAULT,
  parameter int HIGH_WM      = 12,
  parameter int LOW_WM       = 4,
  parameter int BACKPRESSURE = 1,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_valid,
  output logic              rx_data_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  input  logic              flush,
  input  logic              err_clr,
  output logic              overrun,
  output logic [LVL_W-1:0]  level,
  output logic              flow_ok
`ifdef UART_FIFO_BRIDGE_STATS_EN
  ,
  output logic [31:0]       rx_count,
  output logic [31:0]       tx_count,
  output logic [15:0]       drop_count
`endif
);

  localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WM);
  localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WM);

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head_data;
  flow_state_t       flow_state;

  // Ready is a function of fill state only, never of the TX side.
  assign rx_data_ready = (BACKPRESSURE != 0) ? !full : 1'b1;
  assign push          = rx_data_valid && rx_data_ready && !full;
  assign tx_data_valid = !empty;
  assign pop           = tx_data_valid && tx_data_ready;
  assign drop          = (BACKPRESSURE == 0) && rx_data_valid && full;
  assign tx_data       = empty ? '0 : head_data;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (rx_data),
    .rd_data (head_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // A drop in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (err_clr) overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flow_state <= XON;
    end else begin
      case (flow_state)
        XON:     if (level >= HIGH_LVL) flow_state <= XOFF;
        XOFF:    if (level <= LOW_LVL)  flow_state <= XON;
        default: flow_state <= XON;
      endcase
    end
  end

  assign flow_ok = (flow_state == XON);

`ifdef UART_FIFO_BRIDGE_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Flush suppresses the push/pop but leaves the totals intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count   <= '0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (push && !flush) rx_count   <= rx_count + 32'd1;
      if (pop && !flush)  tx_count   <= tx_count + 32'd1;
      if (drop)           drop_count <= sat_inc16(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Random and directed stimulus for two bridge instances (backpressure and drop policy)
// checked each cycle against a list-based behavioural model.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       tx_data_ready;
  logic       flush;
  logic       err_clr;

  logic       rdy0, rdy1, txv0, txv1, ovr0, ovr1, fok0, fok1;
  logic [7:0] txd0, txd1;
  logic [4:0] lvl0, lvl1;
`ifdef UART_FIFO_BRIDGE_STATS_EN
  logic [31:0] rxc0, rxc1, txc0, txc1;
  logic [15:0] drc0, drc1;
`endif

  int total = 0;
  int bad   = 0;

  int mq   [2][0:31];
  int mcnt [2];
  bit movr [2];
  bit mflow[2];
  int m_rxc[2];
  int m_txc[2];
  int m_drc[2];

  always #5 clk = ~clk;

  uart_fifo_bridge #(.BACKPRESSURE(1)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rdy0), .tx_data(txd0), .tx_data_valid(txv0),
    .tx_data_ready(tx_data_ready), .flush(flush), .err_clr(err_clr),
    .overrun(ovr0), .level(lvl0), .flow_ok(fok0)
`ifdef UART_FIFO_BRIDGE_STATS_EN
    , .rx_count(rxc0), .tx_count(txc0), .drop_count(drc0)
`endif
  );

  uart_fifo_bridge #(.BACKPRESSURE(0)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rdy1), .tx_data(txd1), .tx_data_valid(txv1),
    .tx_data_ready(tx_data_ready), .flush(flush), .err_clr(err_clr),
    .overrun(ovr1), .level(lvl1), .flow_ok(fok1)
`ifdef UART_FIFO_BRIDGE_STATS_EN
    , .rx_count(rxc1), .tx_count(txc1), .drop_count(drc1)
`endif
  );

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO as an ordered list, level as its length.
  task automatic model_edge(input bit r, input bit rxv, input int rxd, input bit txr,
                            input bit fl, input bit ec);
    for (int d = 0; d < 2; d++) begin
      bit bp, full, psh, pp, drp;
      if (r) begin
        mcnt[d] = 0; movr[d] = 0; mflow[d] = 1;
        m_rxc[d] = 0; m_txc[d] = 0; m_drc[d] = 0;
        continue;
      end
      bp   = (d == 0);
      full = (mcnt[d] == 16);
      psh  = rxv && !full && !fl;
      pp   = (mcnt[d] > 0) && txr && !fl;
      drp  = !bp && rxv && full;
      if (mflow[d] && mcnt[d] >= 12) mflow[d] = 0;
      else if (!mflow[d] && mcnt[d] <= 4) mflow[d] = 1;
      if (fl) mcnt[d] = 0;
      else begin
        if (pp) begin
          for (int i = 0; i < 31; i++) mq[d][i] = mq[d][i+1];
          mcnt[d]--;
        end
        if (psh) begin
          mq[d][mcnt[d]] = rxd;
          mcnt[d]++;
        end
      end
      if (drp) movr[d] = 1;
      else if (ec) movr[d] = 0;
      if (psh) m_rxc[d]++;
      if (pp)  m_txc[d]++;
      if (drp && m_drc[d] < 65535) m_drc[d]++;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int lv, dt;
      bit rd, tv, ov, fo;
      lv = (d == 0) ? int'(lvl0) : int'(lvl1);
      dt = (d == 0) ? int'(txd0) : int'(txd1);
      rd = (d == 0) ? rdy0 : rdy1;
      tv = (d == 0) ? txv0 : txv1;
      ov = (d == 0) ? ovr0 : ovr1;
      fo = (d == 0) ? fok0 : fok1;
      chk($sformatf("d%0d_level", d), lv, mcnt[d]);
      chk($sformatf("d%0d_tx_valid", d), tv, mcnt[d] > 0);
      chk($sformatf("d%0d_tx_data", d), dt, (mcnt[d] > 0) ? mq[d][0] : 0);
      chk($sformatf("d%0d_rx_ready", d), rd, (d == 0) ? (mcnt[d] < 16) : 1);
      chk($sformatf("d%0d_overrun", d), ov, movr[d]);
      chk($sformatf("d%0d_flow_ok", d), fo, mflow[d]);
`ifdef UART_FIFO_BRIDGE_STATS_EN
      chk($sformatf("d%0d_rx_count", d), (d == 0) ? rxc0 : rxc1, m_rxc[d]);
      chk($sformatf("d%0d_tx_count", d), (d == 0) ? txc0 : txc1, m_txc[d]);
      chk($sformatf("d%0d_drop_count", d), (d == 0) ? drc0 : drc1, m_drc[d]);
`endif
    end
  endtask

  task automatic step(input bit r, input bit rxv, input int rxd, input bit txr,
                      input bit fl, input bit ec);
    rst = r; rx_data_valid = rxv; rx_data = rxd[7:0];
    tx_data_ready = txr; flush = fl; err_clr = ec;
    @(posedge clk);
    model_edge(r, rxv, rxd, txr, fl, ec);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; movr[d] = 0; mflow[d] = 1;
      m_rxc[d] = 0; m_txc[d] = 0; m_drc[d] = 0;
    end
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 8'h99, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Ordering and show-ahead head.
    step(0, 1, 8'h41, 0, 0, 0);
    step(0, 1, 8'h42, 0, 0, 0);
    step(0, 1, 8'h43, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

    // Fill to full, then push+pop on the full cycle, then drops with err_clr.
    for (int i = 0; i < 17; i++) step(0, 1, 8'h10 + i, 0, 0, 0);
    step(0, 1, 8'h77, 1, 0, 0);
    step(0, 1, 8'h55, 0, 0, 0);
    step(0, 1, 8'h55, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Drain through both watermarks.
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 0, 0);

    // Flush with a simultaneous push at level 9.
    for (int i = 0; i < 9; i++) step(0, 1, 8'h60 + i, 0, 0, 0);
    step(0, 1, 8'hAA, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // Reset mid-burst at level 7.
    for (int i = 0; i < 7; i++) step(0, 1, 8'h30 + i, 0, 0, 0);
    step(1, 1, 8'h3F, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomised traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit rv, tr, fl, ec, r;
      ph = (i / 150) % 3;
      rv = ($urandom_range(0, 99) < ((ph == 0) ? 85 : (ph == 1) ? 20 : 50));
      tr = ($urandom_range(0, 99) < ((ph == 0) ? 25 : (ph == 1) ? 85 : 50));
      fl = ($urandom_range(0, 199) == 0);
      ec = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 999) == 0);
      step(r, rv, int'($urandom_range(0, 255)), tr, fl, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
